// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, FSM state type and one-hot helper for the round-robin arbiter
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    function automatic logic [N_REQ-1:0] idx2oh(input logic [IDX_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: rotating-priority 8-to-3 encoder; first unmasked request at or after ptr
module rr_pick8 import arb_pkg::*; (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N_REQ-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [N_REQ-1:0]   m;
    logic [2*N_REQ-1:0] dbl;
    logic [IDX_W-1:0]   lo;

    assign m   = req & ~mask;
    assign dbl = {m, m} >> ptr;
    assign any = |m;
    assign idx = lo + ptr;

    // Descending scan so the lowest set bit of the rotated vector wins
    always_comb begin
        lo = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (dbl[i]) lo = IDX_W'(i);
    end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters with grant hold and optional hold-limit preemption
module rr_arbiter8 import arb_pkg::*; #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);
    arb_state_t       state, state_n;
    logic [IDX_W-1:0] ptr, pick_idx;
    logic [N_REQ-1:0] mask;
    logic [CNT_W-1:0] cnt;
    logic             pick_any, preempt, keep, grant;

    rr_pick8 u_pick (.req(req), .ptr(ptr), .mask(mask), .idx(pick_idx), .any(pick_any));

    // Excluding the owner makes pick_any mean "someone else is waiting"
    assign mask    = (state == ARB_BUSY) ? idx2oh(gnt_idx) : '0;
    assign preempt = (HOLD_MAX != 0) && (cnt >= CNT_W'(HOLD_MAX - 1)) && pick_any;

    always_comb begin
        keep    = en && (state == ARB_BUSY) && req[gnt_idx] && !preempt;
        grant   = en && !keep && pick_any;
        state_n = (keep || grant) ? ARB_BUSY : ARB_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            gnt_valid <= keep || grant;
            gnt       <= grant ? idx2oh(pick_idx) : (keep ? gnt : '0);
            cnt       <= keep ? ((cnt == '1) ? cnt : cnt + CNT_W'(1)) : '0;
            if (grant) begin
                gnt_idx <= pick_idx;
                ptr     <= pick_idx + IDX_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: scoreboard bench; a per-cycle reference model queues expected outputs, a monitor compares
module tb_rr_arbiter8;
    localparam int HM = 4;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
    } exp_t;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b1;
    logic [7:0] req = 8'hFF, gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    exp_t q[$];
    int compared = 0, mismatched = 0;
    int owner = -1, ptr = 0, idx = 0, held = 0;

    rr_arbiter8 #(.HOLD_MAX(HM), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
    );

    always #5 clk = ~clk;

    function automatic int first_from(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++)
            if (r[(p + i) % 8]) return (p + i) % 8;
        return -1;
    endfunction

    // Reference: owner/ptr/held-cycles bookkeeping straight from the arbitration rules
    always @(posedge clk) begin
        logic [7:0] others;
        int k;
        others = req;
        if (owner >= 0) others[owner] = 1'b0;
        k = first_from(others, ptr);
        if (rst) begin
            owner = -1; ptr = 0; idx = 0; held = 0;
        end else if (!en) begin
            owner = -1; held = 0;
        end else if (owner >= 0 && req[owner] && !(HM != 0 && held >= HM && k >= 0)) begin
            held++;
        end else if (k >= 0) begin
            owner = k; idx = k; ptr = (k + 1) % 8; held = 1;
        end else begin
            owner = -1; held = 0;
        end
        q.push_back('{(owner >= 0) ? (8'h01 << owner) : 8'h00, 3'(idx), owner >= 0});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("gnt", 32'(gnt), 32'(e.gnt));
            chk("gnt_idx", 32'(gnt_idx), 32'(e.idx));
            chk("gnt_valid", 32'(gnt_valid), 32'(e.valid));
            chk("onehot_consistent", 32'($countones(gnt) <= 1 && gnt_valid == (gnt != 8'h00)), 32'd1);
        end
    end

    task automatic step(input logic [7:0] r, input logic e, input logic rs);
        req = r; en = e; rst = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] r;
        step(8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) step(8'hFF & ~gnt, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(8'h20, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(8'h09, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h04, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(8'h04, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(8'h05, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(8'h40, 1'b1, 1'b0);
        step(8'h42, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(8'h42, 1'b1, 1'b0);
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) r = 8'($urandom);
            if ($urandom_range(3) == 0) r = r & ~gnt;
            step(r, $urandom_range(15) != 0, $urandom_range(199) == 0);
        end
        for (int i = 0; i < 2; i++) step(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter sharing one resource among 8 requesters. Built around an 8-to-3 encoder: a rotating-priority pick reduces the pending `req` vector to a 3-bit index, which is registered as a one-hot grant plus encoded index. Grants are held while the owner keeps `req` high. An optional hold limit forces hand-off to waiting requesters. Sits between the requester blocks and the shared datapath, whose mux select is `gnt_idx`.

## Interface
- `HOLD_MAX`, default 16: maximum cycles a grant may be held while other requests are pending; 0 disables preemption.
- `CNT_W`, default 5: hold counter width; must satisfy 2^CNT_W > HOLD_MAX.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: arbiter enable; when low, no grant is issued or held.
- `req` in 8: level request per requester; bit i is requester i.
- `gnt` out 8: registered one-hot grant; all zero when idle.
- `gnt_idx` out 3: encoded index of the granted requester; holds its last value when idle.
- `gnt_valid` out 1: high when any grant is active; equals |gnt.

## Operation
- FSM states:
  - IDLE: no grant.
  - BUSY: one owner, `gnt[owner]`=1.
- Priority pointer `ptr` (3 bits):
  - Search order is ptr, ptr+1, …, ptr+7, mod 8.
  - After granting index k, `ptr` becomes k+1 mod 8; 7 wraps to 0.
- IDLE transitions:
  - `en`=1 and `req`≠0: pick the first set bit in search order, go to BUSY, clear the hold counter.
  - Otherwise stay in IDLE.
- BUSY, owner release (`req[owner]`=0):
  - Other bits pending and `en`=1: hand off directly to the next pick, with no idle gap.
  - Otherwise go to IDLE.
- BUSY, owner holds (`req[owner]`=1):
  - Hold counter increments each cycle, saturating.
  - If HOLD_MAX≠0, counter = HOLD_MAX−1, and another request is pending: preempt.
  - Preemption grants the next pick, excluding the owner; the owner goes to the back through the `ptr` update.
  - With no other request pending, the owner keeps the grant indefinitely; the counter saturates and does not preempt.
- `en`=0 in any state:
  - Next cycle: state IDLE, `gnt`=0, `gnt_valid`=0.
  - `ptr` and `gnt_idx` are retained; the counter is cleared.
- At most one `gnt` bit is ever set; `gnt` is never non-zero while `gnt_valid`=0.
- Reset values: state IDLE, `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `ptr`=0, counter=0.

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled at edge t gives `gnt` visible after edge t (next cycle).
- Release-to-regrant latency is 1 cycle: owner drops `req` in cycle t, and the new owner's `gnt` is high in cycle t+1.
  - The old `gnt` bit and the new `gnt` bit are never high together.
- Preemption: the owner receives exactly HOLD_MAX consecutive grant cycles when contended.
- Simultaneous owner release and `en`=0: `en` wins, and the arbiter goes to IDLE.
- Requests that appear and drop within the same cycle as another grant are ignored; there is no request latching.
- Reset mid-grant: `gnt` is zero on the cycle after the `rst` edge, and `ptr` restarts at 0.
- All outputs are registered; there is no combinational path from `req` to `gnt`.

## Structure
- Package `arb_pkg`:
  - Constants: `N_REQ`=8, `IDX_W`=3.
  - FSM state enum: `ARB_IDLE`, `ARB_BUSY`.
- Sub-module `rr_pick8`, combinational:
  - Inputs: `req[7:0]`, `ptr[2:0]`, `mask[7:0]`.
  - Outputs: `idx[2:0]`, `any`.
  - Implementation: rotate `req & ~mask` right by `ptr`, encode the lowest set bit, add `ptr` mod 8.
  - The mask excludes the owner on handoff and preemption.
- Top level holds the FSM, `ptr`, hold counter and output registers.

## Test plan
1. Reset with `req`=8'hFF, `en`=1: `gnt`=0 and `gnt_valid`=0 for the `rst` cycle; the first grant after release is `gnt`=8'h01, `gnt_idx`=0.
2. `req`=8'hFF, each owner drops `req` for one cycle after grant: grant order 0,1,2,…,7,0 with no idle cycles; exactly one `gnt` bit set at all times.
3. Only `req[5]` high: `gnt`=8'h20 one cycle later. Drop `req[5]`: `gnt`=0 the next cycle.
4. HOLD_MAX=4, `req`=8'h09 held constant: grants alternate 0 (4 cycles), 3 (4 cycles), 0, …
5. Owner 2 granted, then `en` low for 3 cycles: `gnt`=0 the next cycle with `gnt_idx` still 2. Re-raise `en` with `req`=8'h05: grant goes to 0 (`ptr`=3 wraps).
6. Owner 6 granted, assert `rst` one cycle: `gnt`=0 the next cycle. With `req`=8'h40|8'h02, the first grant after reset is index 1.
